// File: rtl/dyadic_boolean_operator_decoder_pkg.sv
// Shared truth-table definitions for the dyadic Boolean operator and its decoder.
// Truth-table bit m holds the operator output for minterm m = {A, B}.
package dyadic_boolean_operator_decoder_pkg;

    localparam int TT_WIDTH  = 4;
    localparam int SEL_WIDTH = 2;

    typedef logic [TT_WIDTH-1:0] tt_t;

    typedef enum logic [TT_WIDTH-1:0] {
        TT_FALSE       = 4'b0000,
        TT_NOR         = 4'b0001,
        TT_NOT_A_AND_B = 4'b0010,
        TT_NOT_A       = 4'b0011,
        TT_A_AND_NOT_B = 4'b0100,
        TT_NOT_B       = 4'b0101,
        TT_XOR         = 4'b0110,
        TT_NAND        = 4'b0111,
        TT_AND         = 4'b1000,
        TT_XNOR        = 4'b1001,
        TT_B           = 4'b1010,
        TT_NOT_A_OR_B  = 4'b1011,
        TT_A           = 4'b1100,
        TT_A_OR_NOT_B  = 4'b1101,
        TT_OR          = 4'b1110,
        TT_TRUE        = 4'b1111
    } tt_op_e;

    typedef enum logic {
        ST_ACCUM  = 1'b0,
        ST_REPORT = 1'b1
    } state_e;

    typedef struct packed {
        tt_t  truth_table;
        tt_t  known;
        logic conflict;
        logic complete;
    } report_t;

    function automatic report_t make_report(input tt_t known, input tt_t ones, input tt_t zeros);
        report_t rpt;
        rpt.truth_table = ones & known;
        rpt.known       = known;
        rpt.conflict    = |(ones & zeros);
        rpt.complete    = &known;
        return rpt;
    endfunction

endpackage

// File: rtl/dyadic_boolean_operator_decoder_if.sv
// Sample-stream and report bundle for the decoder; the word_count signal exists
// only when DYADIC_DECODER_WORD_COUNT_EN is defined.
interface dyadic_boolean_operator_decoder_if
    import dyadic_boolean_operator_decoder_pkg::*;
#(
    parameter int WORD_WIDTH  = 8,
    parameter int COUNT_WIDTH = 16
);

    logic                  input_valid;
    logic                  input_ready;
    logic                  input_last;
    logic [WORD_WIDTH-1:0] word_A;
    logic [WORD_WIDTH-1:0] word_B;
    logic [WORD_WIDTH-1:0] result;
    logic                  output_valid;
    logic                  output_ready;
    tt_t                   truth_table;
    tt_t                   truth_table_known;
    logic                  conflict;
    logic                  complete;
`ifdef DYADIC_DECODER_WORD_COUNT_EN
    logic [COUNT_WIDTH-1:0] word_count;
`endif

    modport slave (
`ifdef DYADIC_DECODER_WORD_COUNT_EN
        output word_count,
`endif
        input  input_valid, input_last, word_A, word_B, result, output_ready,
        output input_ready, output_valid, truth_table, truth_table_known, conflict, complete
    );

    modport master (
`ifdef DYADIC_DECODER_WORD_COUNT_EN
        input  word_count,
`endif
        output input_valid, input_last, word_A, word_B, result, output_ready,
        input  input_ready, output_valid, truth_table, truth_table_known, conflict, complete
    );

endinterface

// File: rtl/dyadic_boolean_operator_decoder_observer.sv
// Per-word reduction: which minterms appear in one word and whether each was
// seen producing a 1 and/or a 0.
module dyadic_minterm_observer
    import dyadic_boolean_operator_decoder_pkg::*;
#(
    parameter int WORD_WIDTH = 8
) (
    input  logic [WORD_WIDTH-1:0] word_a_i,
    input  logic [WORD_WIDTH-1:0] word_b_i,
    input  logic [WORD_WIDTH-1:0] result_i,
    output tt_t                   seen_now_o,
    output tt_t                   ones_now_o,
    output tt_t                   zeros_now_o
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latches).
        seen_now_o  = '0;
        ones_now_o  = '0;
        zeros_now_o = '0;
        for (int i = 0; i < WORD_WIDTH; i++) begin
            automatic logic [SEL_WIDTH-1:0] sel = {word_a_i[i], word_b_i[i]};
            seen_now_o[sel] = 1'b1;
            if (result_i[i]) ones_now_o[sel]  = 1'b1;
            else             zeros_now_o[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/dyadic_boolean_operator_decoder.sv
// Recovers a dyadic operator's truth table from (A, B, result) word groups.
// Optional word counter enabled by DYADIC_DECODER_WORD_COUNT_EN.
module dyadic_boolean_operator_decoder
    import dyadic_boolean_operator_decoder_pkg::*;
#(
    parameter int WORD_WIDTH  = 8,
    parameter int COUNT_WIDTH = 16
) (
    input logic                             clock,
    input logic                             clear,
    dyadic_boolean_operator_decoder_if.slave bus
);

    state_e  state_q, state_d;
    tt_t     known_q, known_d;
    tt_t     ones_q, ones_d;
    tt_t     zeros_q, zeros_d;
    report_t report_q, report_d;
    tt_t     seen_now, ones_now, zeros_now;
    logic    in_hs, out_hs;

    dyadic_minterm_observer #(.WORD_WIDTH(WORD_WIDTH)) u_observer (
        .word_a_i    (bus.word_A),
        .word_b_i    (bus.word_B),
        .result_i    (bus.result),
        .seen_now_o  (seen_now),
        .ones_now_o  (ones_now),
        .zeros_now_o (zeros_now)
    );

    assign in_hs  = bus.input_valid  && (state_q == ST_ACCUM);
    assign out_hs = bus.output_ready && (state_q == ST_REPORT);

    always_comb begin
        state_d  = state_q;
        known_d  = known_q;
        ones_d   = ones_q;
        zeros_d  = zeros_q;
        report_d = report_q;
        if (in_hs) begin
            known_d = known_q | seen_now;
            ones_d  = ones_q  | ones_now;
            zeros_d = zeros_q | zeros_now;
            // The report is captured from the updated sums so the last word counts.
            if (bus.input_last) begin
                state_d  = ST_REPORT;
                report_d = make_report(known_d, ones_d, zeros_d);
            end
        end
        if (out_hs) begin
            state_d  = ST_ACCUM;
            known_d  = '0;
            ones_d   = '0;
            zeros_d  = '0;
            report_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (clear) begin
            state_q  <= ST_ACCUM;
            known_q  <= '0;
            ones_q   <= '0;
            zeros_q  <= '0;
            report_q <= '0;
        end else begin
            state_q  <= state_d;
            known_q  <= known_d;
            ones_q   <= ones_d;
            zeros_q  <= zeros_d;
            report_q <= report_d;
        end
    end

    assign bus.input_ready       = (state_q == ST_ACCUM);
    assign bus.output_valid      = (state_q == ST_REPORT);
    assign bus.truth_table       = report_q.truth_table;
    assign bus.truth_table_known = report_q.known;
    assign bus.conflict          = report_q.conflict;
    assign bus.complete          = report_q.complete;

`ifdef DYADIC_DECODER_WORD_COUNT_EN
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (in_hs && (count_q != '1)) count_d = count_q + 1'b1;
        if (out_hs)                   count_d = '0;
    end

    always_ff @(posedge clock) begin
        if (clear) count_q <= '0;
        else       count_q <= count_d;
    end

    assign bus.word_count = count_q;
`endif

endmodule

// File: tb/tb_dyadic_boolean_operator_decoder.sv
// Self-checking bench: directed cases plus random groups scored against a
// per-minterm occurrence-count model.
module tb_dyadic_boolean_operator_decoder;
    import dyadic_boolean_operator_decoder_pkg::*;

    localparam int WW = 4;
    localparam int CW = 16;

    logic clk;
    logic clr;
    int   checks = 0;
    int   errors = 0;
    int   n_ones[4];
    int   n_zeros[4];
    int   n_words;

    dyadic_boolean_operator_decoder_if #(.WORD_WIDTH(WW), .COUNT_WIDTH(CW)) bus ();

    dyadic_boolean_operator_decoder #(.WORD_WIDTH(WW), .COUNT_WIDTH(CW)) dut (
        .clock (clk),
        .clear (clr),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int m = 0; m < 4; m++) begin
            n_ones[m]  = 0;
            n_zeros[m] = 0;
        end
        n_words = 0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_clear();
    endtask

    // Drive one word for exactly one handshake cycle and record it in the model.
    task automatic send_word(input logic [WW-1:0] a, input logic [WW-1:0] b,
                             input logic [WW-1:0] r, input logic last);
        @(negedge clk);
        check("in_ready_before_word", bus.input_ready, 1);
        bus.input_valid = 1'b1;
        bus.input_last  = last;
        bus.word_A      = a;
        bus.word_B      = b;
        bus.result      = r;
        @(posedge clk);
        #1;
        bus.input_valid = 1'b0;
        bus.input_last  = 1'b0;
        for (int i = 0; i < WW; i++) begin
            automatic int m = 2 * int'(a[i]) + int'(b[i]);
            if (r[i]) n_ones[m]++;
            else      n_zeros[m]++;
        end
        n_words++;
    endtask

    task automatic check_report(input string tag);
        tt_t  e_tt = '0;
        tt_t  e_kn = '0;
        logic e_cf = 1'b0;
        for (int m = 0; m < 4; m++) begin
            if (n_ones[m] > 0)                e_tt[m] = 1'b1;
            if (n_ones[m] + n_zeros[m] > 0)   e_kn[m] = 1'b1;
            if (n_ones[m] > 0 && n_zeros[m] > 0) e_cf = 1'b1;
        end
        @(negedge clk);
        check({tag, ".out_valid"}, bus.output_valid, 1);
        check({tag, ".in_ready"}, bus.input_ready, 0);
        check({tag, ".truth_table"}, bus.truth_table, e_tt);
        check({tag, ".known"}, bus.truth_table_known, e_kn);
        check({tag, ".conflict"}, bus.conflict, e_cf);
        check({tag, ".complete"}, bus.complete, (e_kn == 4'hF));
`ifdef DYADIC_DECODER_WORD_COUNT_EN
        check({tag, ".word_count"}, bus.word_count, n_words);
`endif
    endtask

    task automatic accept_report(input string tag);
        bus.output_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.output_ready = 1'b0;
        model_clear();
        @(negedge clk);
        check({tag, ".accept_in_ready"}, bus.input_ready, 1);
        check({tag, ".accept_out_valid"}, bus.output_valid, 0);
`ifdef DYADIC_DECODER_WORD_COUNT_EN
        check({tag, ".accept_count"}, bus.word_count, 0);
`endif
    endtask

    initial begin
        clr              = 1'b1;
        bus.input_valid  = 1'b0;
        bus.input_last   = 1'b0;
        bus.word_A       = '0;
        bus.word_B       = '0;
        bus.result       = '0;
        bus.output_ready = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        clr = 1'b0;

        // Reset state
        check("rst.in_ready", bus.input_ready, 1);
        check("rst.out_valid", bus.output_valid, 0);
        check("rst.truth_table", bus.truth_table, 0);
        check("rst.known", bus.truth_table_known, 0);
        check("rst.conflict", bus.conflict, 0);
        check("rst.complete", bus.complete, 0);
`ifdef DYADIC_DECODER_WORD_COUNT_EN
        check("rst.word_count", bus.word_count, 0);
`endif

        // AND, single word
        send_word(4'b0011, 4'b0101, 4'b0001, 1'b1);
        check_report("and");
        check("and.tt_const", bus.truth_table, TT_AND);
        check("and.known_const", bus.truth_table_known, 4'b1111);
        accept_report("and");

        // XOR partially observed over two words
        send_word(4'b0000, 4'b0000, 4'b0000, 1'b0);
        send_word(4'b1111, 4'b0000, 4'b1111, 1'b1);
        check_report("xor_part");
        check("xor_part.tt_const", bus.truth_table, 4'b0100);
        check("xor_part.known_const", bus.truth_table_known, 4'b0101);
        accept_report("xor_part");

        // Intra-word conflict
        send_word(4'b0011, 4'b0011, 4'b0001, 1'b1);
        check_report("conflict");
        check("conflict.flag_const", bus.conflict, 1);
        check("conflict.known_const", bus.truth_table_known, 4'b1001);
        check("conflict.tt_const", bus.truth_table, 4'b1000);
        accept_report("conflict");

        // Backpressure, with junk offered on the input side that must be ignored
        send_word(4'b0011, 4'b0101, 4'b0110, 1'b1);
        check_report("bp");
        bus.input_valid = 1'b1;
        bus.input_last  = 1'b1;
        bus.word_A      = 4'b1111;
        bus.word_B      = 4'b1111;
        bus.result      = 4'b0000;
        for (int k = 0; k < 3; k++) check_report("bp_hold");
        bus.input_valid = 1'b0;
        bus.input_last  = 1'b0;
        check("bp.tt_const", bus.truth_table, TT_XOR);
        accept_report("bp");
        send_word(4'b0011, 4'b0101, 4'b0111, 1'b1);
        check_report("or_after_bp");
        check("or_after_bp.tt_const", bus.truth_table, TT_OR);
        accept_report("or_after_bp");

        // Idle cycles and a stray input_last without input_valid hold the group open
        send_word(4'b1100, 4'b1010, 4'b1000, 1'b0);
        bus.input_last = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("idle.out_valid", bus.output_valid, 0);
        end
        bus.input_last = 1'b0;
        send_word(4'b0011, 4'b0101, 4'b0000, 1'b1);
        check_report("idle");
        accept_report("idle");

        // clear mid-group leaves no residue
        send_word(4'b1111, 4'b1111, 4'b0000, 1'b0);
        do_clear();
        send_word(4'b0011, 4'b0101, 4'b0001, 1'b1);
        check_report("clr_group");
        check("clr_group.tt_const", bus.truth_table, TT_AND);
        check("clr_group.conflict_const", bus.conflict, 0);
        accept_report("clr_group");

        // clear mid-report
        send_word(4'b0011, 4'b0101, 4'b1110, 1'b1);
        check_report("clr_rpt");
        do_clear();
        check("clr_rpt.out_valid", bus.output_valid, 0);
        check("clr_rpt.in_ready", bus.input_ready, 1);
        check("clr_rpt.truth_table", bus.truth_table, 0);
        check("clr_rpt.known", bus.truth_table_known, 0);

        // Five-word group (word_count = 5 when the counter is built in)
        for (int k = 0; k < 5; k++)
            send_word(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15)), k == 4);
        check_report("five");
        accept_report("five");

        // Random groups with random gaps and backpressure
        for (int g = 0; g < 25; g++) begin
            automatic int nw = $urandom_range(1, 5);
            for (int k = 0; k < nw; k++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send_word(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          4'($urandom_range(0, 15)), k == nw - 1);
            end
            check_report("rand");
            repeat ($urandom_range(0, 3)) check_report("rand_hold");
            accept_report("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
